// File: rtl/fir_coeff_ctrl.sv
// Coefficient controller in front of the FIR datapath: shadow bank written tap
// by tap, committed by stalling upstream, flushing with zeros, then swapping.
module fir_coeff_ctrl #(
  parameter int TAPS         = 8,
  parameter int COEFF_WIDTH  = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 3,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]         cfg_addr,
  input  logic [COEFF_WIDTH-1:0]        cfg_wr_data,
  input  logic                          cfg_commit,
  output logic                          cfg_busy,
  input  logic [DATA_WIDTH-1:0]         s_sample,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         fir_sample,
  output logic                          fir_valid,
  output logic [TAPS*COEFF_WIDTH-1:0]   coeff_bus,
  output logic                          coeff_update,
  output logic [7:0]                    commit_count
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;

  localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  logic [1:0]                  state_q, state_d;
  logic [CNT_W-1:0]            flush_cnt_q, flush_cnt_d;
  logic [TAPS*COEFF_WIDTH-1:0] shadow_q, shadow_d;
  logic [TAPS*COEFF_WIDTH-1:0] active_q, active_d;
  logic [DATA_WIDTH-1:0]       fir_sample_q, fir_sample_d;
  logic                        fir_valid_q, fir_valid_d;
  logic                        coeff_update_q, coeff_update_d;
  logic [7:0]                  commit_count_q, commit_count_d;
  logic                        run_s;

  assign run_s        = (state_q == ST_RUN);
  assign s_ready      = run_s;
  assign cfg_busy     = ~run_s;
  assign fir_sample   = fir_sample_q;
  assign fir_valid    = fir_valid_q;
  assign coeff_bus    = active_q;
  assign coeff_update = coeff_update_q;
  assign commit_count = commit_count_q;

  // Shadow bank: only RUN-state writes to an existing tap land; others are dropped.
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < TAPS; k++) begin
      if (run_s && cfg_wr_en && (cfg_addr == ADDR_WIDTH'(k))) begin
        shadow_d[k*COEFF_WIDTH +: COEFF_WIDTH] = cfg_wr_data;
      end else begin
        shadow_d[k*COEFF_WIDTH +: COEFF_WIDTH] = shadow_q[k*COEFF_WIDTH +: COEFF_WIDTH];
      end
    end
  end

  // Sequencer and FIR-side output next-state logic.
  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    active_d       = active_q;
    fir_sample_d   = fir_sample_q;
    fir_valid_d    = 1'b0;
    coeff_update_d = 1'b0;
    commit_count_d = commit_count_q;
    case (state_q)
      ST_RUN: begin
        fir_valid_d = s_valid;
        if (s_valid) begin
          fir_sample_d = s_sample;
        end else begin
          fir_sample_d = fir_sample_q;
        end
        if (cfg_commit) begin
          if (FLUSH_CYCLES > 0) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end else begin
            state_d     = ST_SWAP;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Zero-valued valid samples push old history out of the delay line.
        fir_valid_d  = 1'b1;
        fir_sample_d = {DATA_WIDTH{1'b0}};
        flush_cnt_d  = flush_cnt_q - CNT_W'(1);
        if (flush_cnt_q == CNT_W'(1)) begin
          state_d = ST_SWAP;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_SWAP: begin
        active_d       = shadow_q;
        commit_count_d = commit_count_q + 8'd1;
        coeff_update_d = 1'b1;
        fir_valid_d    = 1'b0;
        state_d        = ST_RUN;
      end
      default: begin
        state_d     = ST_RUN;
        fir_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      flush_cnt_q    <= {CNT_W{1'b0}};
      shadow_q       <= {(TAPS*COEFF_WIDTH){1'b0}};
      active_q       <= {(TAPS*COEFF_WIDTH){1'b0}};
      fir_sample_q   <= {DATA_WIDTH{1'b0}};
      fir_valid_q    <= 1'b0;
      coeff_update_q <= 1'b0;
      commit_count_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      fir_sample_q   <= fir_sample_d;
      fir_valid_q    <= fir_valid_d;
      coeff_update_q <= coeff_update_d;
      commit_count_q <= commit_count_d;
    end
  end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: a default instance (8 taps, 8 flush cycles)
// and an edge instance (6 taps, no flush).
module tb_fir_coeff_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance
  logic         wr_en = 1'b0, commit = 1'b0, s_valid = 1'b0;
  logic [2:0]   addr = 3'd0;
  logic [15:0]  wr_data = 16'd0, s_sample = 16'd0;
  logic         busy, s_ready, fir_valid, coeff_update;
  logic [15:0]  fir_sample;
  logic [127:0] coeff_bus;
  logic [7:0]   commit_count;

  // Edge instance
  logic         b_wr_en = 1'b0, b_commit = 1'b0, b_s_valid = 1'b0;
  logic [2:0]   b_addr = 3'd0;
  logic [15:0]  b_wr_data = 16'd0, b_s_sample = 16'd0;
  logic         b_busy, b_s_ready, b_fir_valid, b_coeff_update;
  logic [15:0]  b_fir_sample;
  logic [95:0]  b_coeff_bus;
  logic [7:0]   b_commit_count;

  int vectors = 0;
  int miscompares = 0;

  fir_coeff_ctrl dut (
    .clk(clk), .rst(rst), .cfg_wr_en(wr_en), .cfg_addr(addr), .cfg_wr_data(wr_data),
    .cfg_commit(commit), .cfg_busy(busy), .s_sample(s_sample), .s_valid(s_valid),
    .s_ready(s_ready), .fir_sample(fir_sample), .fir_valid(fir_valid),
    .coeff_bus(coeff_bus), .coeff_update(coeff_update), .commit_count(commit_count)
  );

  fir_coeff_ctrl #(.TAPS(6), .FLUSH_CYCLES(0)) dut_edge (
    .clk(clk), .rst(rst), .cfg_wr_en(b_wr_en), .cfg_addr(b_addr), .cfg_wr_data(b_wr_data),
    .cfg_commit(b_commit), .cfg_busy(b_busy), .s_sample(b_s_sample), .s_valid(b_s_valid),
    .s_ready(b_s_ready), .fir_sample(b_fir_sample), .fir_valid(b_fir_valid),
    .coeff_bus(b_coeff_bus), .coeff_update(b_coeff_update), .commit_count(b_commit_count)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] exp_bus;

  initial begin
    // Reset then idle
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("rst_coeff", coeff_bus, 128'd0);
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fvalid", fir_valid, 1'b0);
    chk("rst_count", commit_count, 8'd0);

    // Load all taps with 0x1000
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; addr = 3'(k); wr_data = 16'h1000;
      step();
    end
    wr_en = 1'b0;
    chk("shadow_not_live", coeff_bus, 128'd0);

    // Commit at T with sample 100 accepted in the same cycle
    commit = 1'b1; s_valid = 1'b1; s_sample = 16'd100;
    step();                                   // T+1
    commit = 1'b0; s_valid = 1'b0;
    chk("t1_fvalid", fir_valid, 1'b1);
    chk("t1_fsample", fir_sample, 16'd100);
    chk("t1_ready", s_ready, 1'b0);
    chk("t1_busy", busy, 1'b1);
    for (int i = 2; i <= 9; i++) begin        // T+2 .. T+9
      step();
      chk("flush_fvalid", fir_valid, 1'b1);
      chk("flush_fsample", fir_sample, 16'd0);
      chk("flush_ready", s_ready, 1'b0);
      chk("flush_coeff", coeff_bus, 128'd0);
      chk("flush_upd", coeff_update, 1'b0);
    end
    step();                                   // T+10
    chk("swap_coeff", coeff_bus, {8{16'h1000}});
    chk("swap_upd", coeff_update, 1'b1);
    chk("swap_count", commit_count, 8'd1);
    chk("swap_ready", s_ready, 1'b1);
    chk("swap_fvalid", fir_valid, 1'b0);
    step();                                   // T+11
    chk("upd_pulse", coeff_update, 1'b0);

    // Stall and ignore: commit at T, sample 555 held from T+1, write/commit at T+2
    commit = 1'b1;
    step();                                   // T+1
    commit = 1'b0; s_valid = 1'b1; s_sample = 16'd555;
    step();                                   // T+2
    chk("stall_fsample", fir_sample, 16'd0);
    wr_en = 1'b1; addr = 3'd3; wr_data = 16'h7FFF; commit = 1'b1;
    step();                                   // T+3
    wr_en = 1'b0; commit = 1'b0;
    for (int i = 3; i <= 9; i++) begin
      if (i > 3) step();
      chk("stall_fvalid", fir_valid, 1'b1);
      chk("stall_zero", fir_sample, 16'd0);
    end
    step();                                   // T+10
    chk("stall_swap_fvalid", fir_valid, 1'b0);
    chk("stall_count", commit_count, 8'd2);
    step();                                   // T+11
    s_valid = 1'b0;
    chk("held_fvalid", fir_valid, 1'b1);
    chk("held_fsample", fir_sample, 16'd555);
    chk("no_second_busy", busy, 1'b0);
    step();
    chk("no_second_count", commit_count, 8'd2);
    chk("no_second_busy2", busy, 1'b0);

    // Write and commit in the same cycle; tap 3 must still hold 0x1000
    wr_en = 1'b1; addr = 3'd7; wr_data = 16'h8000; commit = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0;
    repeat (9) step();                        // T+10
    exp_bus = {16'h8000, {7{16'h1000}}};
    chk("wc_coeff", coeff_bus, exp_bus);
    chk("wc_count", commit_count, 8'd3);
    chk("wc_upd", coeff_update, 1'b1);
    // Back-to-back commit in the coeff_update cycle restarts flushing
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_fvalid", fir_valid, 1'b0);
    step();
    chk("b2b_flush", fir_valid, 1'b1);
    repeat (8) step();
    chk("b2b_count", commit_count, 8'd4);
    chk("b2b_upd", coeff_update, 1'b1);

    // Reset at flush count 4 (cycle T+5)
    commit = 1'b1;
    step();                                   // T+1, count 8
    commit = 1'b0;
    repeat (4) step();                        // T+5, count 4
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", s_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_coeff", coeff_bus, 128'd0);
    chk("mid_rst_fvalid", fir_valid, 1'b0);
    chk("mid_rst_count", commit_count, 8'd0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", busy, 1'b0);

    // Edge instance: taps 1..6, out-of-range writes to 6 and 7
    for (int k = 0; k < 8; k++) begin
      b_wr_en = 1'b1; b_addr = 3'(k);
      b_wr_data = (k < 6) ? 16'(k + 1) : 16'hDEAD;
      step();
    end
    b_wr_en = 1'b0;
    b_commit = 1'b1; b_s_valid = 1'b1; b_s_sample = 16'd7;
    step();                                   // T+1: SWAP
    b_commit = 1'b0; b_s_valid = 1'b0;
    chk("f0_fvalid", b_fir_valid, 1'b1);
    chk("f0_fsample", b_fir_sample, 16'd7);
    chk("f0_busy", b_busy, 1'b1);
    chk("f0_coeff_old", b_coeff_bus, 96'd0);
    step();                                   // T+2
    chk("f0_coeff", b_coeff_bus, {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
    chk("f0_upd", b_coeff_update, 1'b1);
    chk("f0_count", b_commit_count, 8'd1);
    chk("f0_fvalid_swap", b_fir_valid, 1'b0);
    chk("f0_ready", b_s_ready, 1'b1);
    b_wr_en = 1'b1; b_addr = 3'd6; b_wr_data = 16'hFFFF;
    step();
    b_addr = 3'd7;
    step();
    b_wr_en = 1'b0; b_commit = 1'b1;
    step();
    b_commit = 1'b0;
    step();
    chk("oor_coeff", b_coeff_bus, {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
    chk("oor_count", b_commit_count, 8'd2);

    // Wrap commit_count through 255 -> 0
    for (int i = 0; i < 253; i++) begin
      b_commit = 1'b1;
      step();
      b_commit = 1'b0;
      step();
    end
    chk("wrap_255", b_commit_count, 8'd255);
    b_commit = 1'b1;
    step();
    b_commit = 1'b0;
    step();
    chk("wrap_0", b_commit_count, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_coeff_ctrl.md
Name: fir_coeff_ctrl

Overview:
- Configuration and sequencing controller placed in front of the `fir` datapath.
- Holds a shadow coefficient bank that software writes tap by tap, and drives the active coefficient bus into the FIR.
- On commit it does three things in order:
  - stalls the upstream sample stream;
  - flushes the FIR delay line with zero-valued valid samples;
  - swaps shadow into active atomically.
- Result: no output sample is ever computed from a mix of old and new coefficients or stale history.

Parameters:
TAPS, 8, number of FIR taps / coefficients
COEFF_WIDTH, 16, signed coefficient width (Q1.15)
DATA_WIDTH, 16, signed sample width
ADDR_WIDTH, 3, coefficient address width (>= clog2(TAPS))
FLUSH_CYCLES, 8, zero samples injected per commit (normally TAPS; 0 allowed)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_wr_en  in  1  write shadow[cfg_addr] <= cfg_wr_data this cycle
cfg_addr  in  ADDR_WIDTH  tap index
cfg_wr_data  in  COEFF_WIDTH  signed coefficient
cfg_commit  in  1  request swap of shadow into active
cfg_busy  out  1  1 while a commit is in progress (state != RUN)
s_sample  in  DATA_WIDTH  upstream sample
s_valid  in  1  upstream sample valid
s_ready  out  1  controller accepts s_sample this cycle
fir_sample  out  DATA_WIDTH  sample to FIR in_sample
fir_valid  out  1  to FIR in_valid
coeff_bus  out  TAPS*COEFF_WIDTH  active coefficients, tap k at bits [k*COEFF_WIDTH +: COEFF_WIDTH]
coeff_update  out  1  one-cycle pulse the first cycle new coefficients are on coeff_bus
commit_count  out  8  number of completed swaps, wraps 255->0

Behaviour:
Reset (asynchronous, active-high):
- State = RUN.
- All shadow and active coefficients = 0.
- fir_sample = 0, fir_valid = 0, coeff_update = 0, commit_count = 0, flush counter = 0.

States: RUN, FLUSH, SWAP.
- cfg_busy = (state != RUN).
- s_ready = (state == RUN), combinational from state.

Output register timing:
- fir_sample / fir_valid are registered, latency 1.
- RUN: fir_valid <= s_valid; fir_sample <= s_sample when s_valid, else it holds its previous value.
- FLUSH: fir_valid <= 1, fir_sample <= 0.
- SWAP: fir_valid <= 0.

RUN state:
- A cfg_wr_en with cfg_addr < TAPS updates the shadow bank. Writes with cfg_addr >= TAPS are ignored.
- On cfg_commit:
  - if FLUSH_CYCLES > 0, go to FLUSH and load the flush counter with FLUSH_CYCLES;
  - otherwise go directly to SWAP.

FLUSH state:
- Decrement the counter each cycle.
- When the counter == 1, go to SWAP. Exactly FLUSH_CYCLES cycles are spent in FLUSH.

SWAP state (one cycle):
- active <= shadow, all taps in the same edge.
- commit_count increments.
- coeff_update <= 1, so it is high in the first RUN cycle and 0 otherwise.
- Next state = RUN.

Timeline for a commit at cycle T with F = FLUSH_CYCLES > 0:
- Sample accepted at T appears on fir_* at T+1.
- Zero valid samples on fir_* at T+2 .. T+F+1.
- SWAP occurs at T+F+1.
- New coeff_bus, coeff_update = 1 and s_ready = 1 at T+F+2.
- fir_valid = 0 at T+F+2.

Boundary rules:
- cfg_wr_en and cfg_commit in the same RUN cycle: the write lands in shadow first and is included in the swap.
- cfg_wr_en and cfg_commit are ignored while cfg_busy = 1. The shadow bank is frozen during FLUSH/SWAP.
- s_valid while s_ready = 0: the sample is not consumed. Upstream must hold it (valid/ready rule: transfer = s_valid & s_ready).
- coeff_bus changes only on the SWAP edge or on reset; it never changes in RUN or FLUSH.
- Reset mid-FLUSH or mid-SWAP: return immediately to RUN with zero coefficients. The pending commit is discarded and commit_count = 0.
- Back-to-back commits: a new commit is accepted only in RUN. The earliest is the cycle coeff_update is high, and it restarts the full FLUSH sequence.

Test Plan:
- Reset then idle:
  - Required: coeff_bus = 0, s_ready = 1, cfg_busy = 0, fir_valid = 0, commit_count = 0.
- Load and swap:
  - Stimulus: write taps 0..7 with 0x1000 each, pulse cfg_commit at T while s_valid = 1 with s_sample = 100.
  - Required fir_* sequence: fir_sample = 100 valid at T+1, then 8 valid zero samples at T+2..T+9.
  - Required swap: coeff_bus = eight 0x1000 at T+10, coeff_update high for exactly 1 cycle, commit_count = 1, s_ready = 0 during T+1..T+9.
- Stall and ignore rules:
  - Stimulus: hold s_valid = 1 with s_sample = 555 and issue cfg_wr_en addr 3 data 0x7FFF during FLUSH.
  - Required: sample 555 emitted only after the return to RUN (at T+11); shadow tap 3 unchanged; no second commit.
- Simultaneous write and commit:
  - Stimulus: cfg_wr_en addr 7 data 0x8000 in the same cycle as cfg_commit.
  - Required: tap 7 of coeff_bus = 0x8000 after the swap.
- Edge parameters:
  - FLUSH_CYCLES = 0: swap follows commit within 1 cycle, with no zero samples.
  - Out-of-range address: a write to addr >= TAPS (TAPS = 6) leaves all taps unchanged.
- Reset mid-operation and wrap:
  - Assert rst at FLUSH count 4: required immediate RUN state, coeff_bus = 0, fir_valid = 0.
  - Perform 256 commits: required commit_count wraps to 0.
